// File: rtl/register_writeback_block_if.sv
// Bus bundle between a result producer and register_writeback_block:
// start/load strobes, captured result buses and the register file read-back.
interface register_writeback_block_if #(
    parameter int DATA_WIDTH      = 4,
    parameter int REGS            = 64,
    parameter int OUTPUTS         = 4,
    parameter int OUTPUTS_PER_BUS = 4
);
    localparam int BUS_W   = DATA_WIDTH * OUTPUTS_PER_BUS;
    localparam int ADDR_W  = $clog2(REGS);
    localparam int FIELD_W = ADDR_W + 1;
    localparam int NIBBLES = OUTPUTS * OUTPUTS_PER_BUS;

    logic                         wStart;
    logic [BUS_W-1:0]             r0;
    logic [BUS_W-1:0]             r1;
    logic [BUS_W-1:0]             r2;
    logic [BUS_W-1:0]             r3;
    logic [FIELD_W*NIBBLES-1:0]   wDest;
    logic                         wLoad;
    logic [ADDR_W-1:0]            wLoadAddr;
    logic [DATA_WIDTH-1:0]        wLoadData;
    logic [DATA_WIDTH*REGS-1:0]   wRegs;
    logic                         wBusy;
    logic                         wDone;

    modport master (
        output wStart, r0, r1, r2, r3, wDest, wLoad, wLoadAddr, wLoadData,
        input  wRegs, wBusy, wDone
    );

    modport slave (
        input  wStart, r0, r1, r2, r3, wDest, wLoad, wLoadAddr, wLoadData,
        output wRegs, wBusy, wDone
    );
endinterface

// File: rtl/register_writeback_block.sv
// Nibble register file with a 4-bus writeback sequencer (one bus per cycle)
// and a host direct-write port that is only honoured while idle.
module register_writeback_block #(
    parameter int DATA_WIDTH      = 4,
    parameter int REGS            = 64,
    parameter int OUTPUTS         = 4,
    parameter int OUTPUTS_PER_BUS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    register_writeback_block_if.slave     bus
);
    localparam int BUS_W   = DATA_WIDTH * OUTPUTS_PER_BUS;
    localparam int ADDR_W  = $clog2(REGS);
    localparam int FIELD_W = ADDR_W + 1;
    localparam int NIBBLES = OUTPUTS * OUTPUTS_PER_BUS;
    localparam int CNT_W   = $clog2(OUTPUTS);
    localparam int SEL_W   = $clog2(OUTPUTS_PER_BUS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wbState;

    wbState                 state;
    wbState                 stateNext;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cntNext;
    logic                   busyR;
    logic                   busyNext;
    logic                   doneR;
    logic                   doneNext;
    logic                   startAccept;
    logic                   loadAccept;

    logic [BUS_W-1:0]       busIn   [OUTPUTS];
    logic [DATA_WIDTH-1:0]  capNib  [OUTPUTS][OUTPUTS_PER_BUS];
    logic [FIELD_W-1:0]     capDest [NIBBLES];
    logic [DATA_WIDTH-1:0]  regs    [REGS];

    // Present the four named result buses as an indexable array.
    always_comb begin
        busIn[0] = bus.r0;
        busIn[1] = bus.r1;
        busIn[2] = bus.r2;
        busIn[3] = bus.r3;
    end

    // State, bus counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= {CNT_W{1'b0}};
            busyR <= 1'b0;
            doneR <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            busyR <= busyNext;
            doneR <= doneNext;
        end
    end

    // Next-state logic; start wins over a same-cycle host load.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        busyNext    = busyR;
        doneNext    = 1'b0;
        startAccept = 1'b0;
        loadAccept  = 1'b0;
        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (bus.wStart) begin
                    stateNext   = WRITE;
                    cntNext     = {CNT_W{1'b0}};
                    busyNext    = 1'b1;
                    startAccept = 1'b1;
                end else if (bus.wLoad) begin
                    loadAccept = 1'b1;
                end else begin
                    loadAccept = 1'b0;
                end
            end
            WRITE: begin
                busyNext = 1'b1;
                if (cnt == CNT_W'(OUTPUTS - 1)) begin
                    stateNext = DONE;
                    cntNext   = {CNT_W{1'b0}};
                    doneNext  = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
                doneNext  = 1'b0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = {CNT_W{1'b0}};
                busyNext  = 1'b0;
                doneNext  = 1'b0;
            end
        endcase
    end

    // Shadow copies of the result buses and destination map, taken on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < OUTPUTS; k++) begin
                for (int j = 0; j < OUTPUTS_PER_BUS; j++) begin
                    capNib[k][j] <= {DATA_WIDTH{1'b0}};
                end
            end
            for (int i = 0; i < NIBBLES; i++) begin
                capDest[i] <= {FIELD_W{1'b0}};
            end
        end else if (startAccept) begin
            for (int k = 0; k < OUTPUTS; k++) begin
                for (int j = 0; j < OUTPUTS_PER_BUS; j++) begin
                    capNib[k][j] <= busIn[k][DATA_WIDTH*j +: DATA_WIDTH];
                end
            end
            for (int i = 0; i < NIBBLES; i++) begin
                capDest[i] <= bus.wDest[FIELD_W*i +: FIELD_W];
            end
        end
    end

    // Register file; within a bus the later (higher j) non-blocking write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < REGS; n++) begin
                regs[n] <= {DATA_WIDTH{1'b0}};
            end
        end else if (state == WRITE) begin
            for (int j = 0; j < OUTPUTS_PER_BUS; j++) begin
                if (capDest[{cnt, SEL_W'(j)}][0]) begin
                    regs[capDest[{cnt, SEL_W'(j)}][FIELD_W-1:1]] <= capNib[cnt][SEL_W'(j)];
                end
            end
        end else if (loadAccept) begin
            regs[bus.wLoadAddr] <= bus.wLoadData;
        end
    end

    // Flatten the register array onto the read-back bus.
    always_comb begin
        bus.wRegs = {(DATA_WIDTH*REGS){1'b0}};
        for (int n = 0; n < REGS; n++) begin
            bus.wRegs[DATA_WIDTH*n +: DATA_WIDTH] = regs[n];
        end
    end

    assign bus.wBusy = busyR;
    assign bus.wDone = doneR;
endmodule

// File: doc/register_writeback_block.md
Name: register_writeback_block

Overview:
Write-side counterpart of input_selector_block: owns the 64-entry nibble register file that input_selector_block reads through its wRegs input. On a start pulse it captures the four 16-bit result buses r0..r3 and a per-nibble destination map. It then writes the enabled nibbles into the register file, one bus per cycle. wBusy from this block drives the wBusy input of input_selector_block.

Parameters:
DATA_WIDTH, 4, bits per register entry and per bus nibble
REGS, 64, number of register entries
OUTPUTS, 4, number of result buses
OUTPUTS_PER_BUS, 4, nibbles per result bus (bus width = DATA_WIDTH*OUTPUTS_PER_BUS = 16)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wStart  input  1  start request, sampled only in IDLE
r0  input  16  result bus 0
r1  input  16  result bus 1
r2  input  16  result bus 2
r3  input  16  result bus 3
wDest  input  112  16 destination fields of 7 bits; field i = wDest[7i+6:7i] = {addr[5:0], en}, en in bit 7i
wLoad  input  1  host direct write strobe
wLoadAddr  input  6  host write register index
wLoadData  input  4  host write data
wRegs  output  256  register file contents; reg n = wRegs[4n+3:4n]
wBusy  output  1  high while a writeback sequence is active
wDone  output  1  one-cycle pulse at sequence completion

Behaviour:
- Reset (reset=1 at an edge): all 64 registers = 0; state IDLE; wBusy=0; wDone=0; capture registers cleared. Reset overrides everything, including mid-sequence: the sequence is aborted and no further writes occur.
- Nibble mapping: nibble j of bus k = rk[4j+3:4j]; it uses destination field i = 4k+j.
- States: IDLE, WRITE (2-bit bus counter cnt), DONE.
- IDLE, wStart=1 at edge E0: capture r0..r3 and wDest into shadow registers; go to WRITE with cnt=0; wBusy=1 after E0. Bus and wDest values after E0 are don't-care.
- WRITE, edges E1..E4: at edge E(cnt+1), for each j=0..3 whose en=1, reg[addr] <= captured nibble j of bus cnt. cnt increments.
  - At E4 (cnt=3) state goes to DONE and wDone=1.
- DONE: at E5 state goes to IDLE, wBusy=0, wDone=0. Total wBusy high = 5 cycles; wDone high exactly 1 cycle (the cycle after E4).
- wStart is ignored in WRITE and DONE; no queuing. The earliest accepted restart is sampled at E5 + 1 edge (state IDLE).
- Address conflict within one bus (two enabled nibbles, same addr): the higher j wins.
- Conflict across buses: the later bus wins (bus 3 is last).
- en=0: that nibble is not written; the target register holds its value.
- Host load: wLoad=1 in IDLE with no wStart in the same cycle writes reg[wLoadAddr] <= wLoadData at that edge.
  - wLoad is ignored when state != IDLE.
  - wLoad is ignored when wStart is accepted in the same cycle (start has priority).
- wRegs is a direct register output: no combinational path from the inputs. A write performed at edge E is visible on wRegs immediately after E.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, reset=0 -> wRegs=256'h0, wBusy=0, wDone=0.
- Full sequence:
  - Stimulus: r0=16'h3210, r1=16'h7654, r2=16'hba98, r3=16'hfedc; field i = {addr=i, en=1}; wStart pulse at E0.
  - Required: wBusy high E0..E5; wRegs[63:0]=64'hfedcba9876543210 after E4; wDone high only in the cycle after E4; wRegs[255:64]=0.
- Per-bus timing: same stimulus -> after E1 only reg0..3 = 0,1,2,3; after E2 reg4..7 = 4..7 are also set; register changes occur at E1..E4 only.
- Conflict and enable:
  - Stimulus: field0={addr 6'h10,en 1}, field1={6'h10,1}, field5={6'h10,1}, field2={6'h11,0}; all other fields en=0; r0=16'h0021, r1=16'h00a0.
  - Required: after E4 reg[16]=4'ha (bus1 nibble1 overwrites bus0 nibble1=2, which had overwritten nibble0=1); reg[17] unchanged.
- Busy rejection:
  - Stimulus: wStart and wLoad (addr 5, data 4'h9) asserted during WRITE and during DONE.
  - Required: no second sequence; reg5 unchanged; wDone pulses once.
  - Follow-up: a wLoad in IDLE afterwards sets reg5=4'h9 at the next edge.
- Reset mid-sequence: assert reset at E2 -> wRegs=0, wBusy=0 after E2; no wDone; bus 2/3 writes never appear.
